// File: rtl/shift_add_mult_32bit.sv
// Sequential radix-2 shift-and-add unsigned multiplier.
// Drives an external ripple-carry adder through the add_* ports.
module shift_add_mult_32bit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_c_in,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_c_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] plo_q, plo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Adder operands come only from registers, never from add_sum.
  assign add_a    = acc_q;
  assign add_b    = plo_q[0] ? mcand_q : '0;
  assign add_c_in = 1'b0;

  assign product = {acc_q, plo_q};
  assign busy    = busy_q;
  assign done    = done_q;

  // Next-state: load on accepted start, shift sum+carry into {acc,plo}.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    plo_d   = plo_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = '0;
          plo_d   = b;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = {add_c_out, add_sum[WIDTH-1:1]};
        plo_d = {add_sum[0], plo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset that discards any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      plo_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      plo_q   <= plo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_shift_add_mult_32bit.sv
// Bench for shift_add_mult_32bit with a behavioural adder.
// Expected products are queued at issue and popped on done.
module tb_shift_add_mult_32bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_c_in;
  logic [31:0] add_sum;
  logic        add_c_out;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp = '0;

  always #5 clk = ~clk;

  assign {add_c_out, add_sum} =
    {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_c_in};

  shift_add_mult_32bit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .busy(busy), .done(done),
    .product(product), .add_a(add_a), .add_b(add_b),
    .add_c_in(add_c_in), .add_sum(add_sum),
    .add_c_out(add_c_out)
  );

  // Scoreboard: every done pulse must match the oldest queued product.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: product=%h with no queued result",
                 product);
      end else begin
        last_exp = exp_q.pop_front();
        if (product !== last_exp) begin
          errors++;
          $display("FAIL product: got %h expected %h", product, last_exp);
        end
      end
    end
  end

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input int poke, input bit chk_b);
    int lat;
    @(posedge clk); #1;
    start = 1'b1; a = ta; b = tb_v;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    exp_q.push_back(64'(ta) * 64'(tb_v));
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == poke) begin
        start = 1'b1; a = 32'd7; b = 32'd7;
      end else if (n == poke + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        lat = n;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_done: got %b expected 0", busy);
        end
        break;
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_run: cycle %0d got %b expected 1", n, busy);
      end
      if (chk_b) begin
        checks++;
        if (add_b !== 32'd0 || add_c_in !== 1'b0) begin
          errors++;
          $display("FAIL add_b_zero: cycle %0d add_b=%h c_in=%b expected 0",
                   n, add_b, add_c_in);
        end
      end
    end
    checks++;
    if (lat != 33) begin
      errors++;
      $display("FAIL latency: got %0d expected 33 (0 = timeout)", lat);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 ||
        product !== 64'(ta) * 64'(tb_v)) begin
      errors++;
      $display("FAIL hold: done=%b busy=%b product=%h expected 0 0 %h",
               done, busy, product, 64'(ta) * 64'(tb_v));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0 ||
        add_c_in !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b product=%h c_in=%b expected 0",
               busy, done, product, add_c_in);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_op(32'd3, 32'd5, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(32'h1234_5678, 32'd0, 0, 1'b1);
    run_op(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 0, 1'b0);
  endtask

  task automatic test_restart_ignored();
    run_op(32'd6, 32'd9, 5, 1'b0);
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    start = 1'b1; a = 32'd11; b = 32'd13;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b product=%h expected 0 0 0",
               busy, done, product);
    end
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL after_reset: cycle %0d done=%b busy=%b expected 0 0",
                 n, done, busy);
      end
    end
    run_op(32'd100, 32'd200, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int d1;
    int d2;
    d1 = 0;
    d2 = 0;
    @(posedge clk); #1;
    start = 1'b1; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    exp_q.push_back(64'd6);
    a = 32'd4; b = 32'd5;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        d1 = n;
        break;
      end
    end
    checks++;
    if (d1 != 33) begin
      errors++;
      $display("FAIL b2b_first: got %0d expected 33", d1);
    end
    @(posedge clk); #1;
    exp_q.push_back(64'd20);
    start = 1'b0; a = $urandom; b = $urandom;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b expected 1", busy);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        d2 = k;
        break;
      end
    end
    checks++;
    if (d2 != 33) begin
      errors++;
      $display("FAIL b2b_interval: got %0d expected 33", d2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      run_op($urandom, $urandom, 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart_ignored();
    test_mid_reset();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d results pending expected 0",
               exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
